// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative RV32M/RV64M multiply/divide unit beside the Execute-stage ALU
module muldiv_unit #(
   parameter int XLEN = 32,
   parameter int CNTW = $clog2(XLEN)
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            start_E,
   input  logic [2:0]      funct3_E,
   input  logic [XLEN-1:0] SrcA_E,
   input  logic [XLEN-1:0] SrcB_E,
   input  logic [4:0]      rd_E,
   input  logic            Flush_E,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] result_M,
   output logic [4:0]      rd_M,
   output logic            stall_req
);

   localparam int              AW       = 2 * XLEN + 1;
   localparam logic [XLEN-1:0] INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};
   localparam logic [CNTW-1:0] CNT_INIT = CNTW'(XLEN - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_ADJ  = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t          state_q, state_d;
   logic [CNTW-1:0] cnt_q, cnt_d;
   logic [2:0]      op_q, op_d;
   logic [4:0]      rd_lat_q, rd_lat_d;
   logic            neg_q, neg_d;
   logic [AW-1:0]   acc_q, acc_d;
   logic [XLEN-1:0] opb_q, opb_d;
   logic [XLEN-1:0] result_q, result_d;
   logic [4:0]      rd_q, rd_d;

   logic            accept, is_mul, signed_a, signed_b, sign_a, sign_b;
   logic            div_zero, div_ovf, fast;
   logic [XLEN-1:0] mag_a, mag_b, fast_res;

   // Request decode: operand magnitudes and the two RISC-V special division cases.
   always_comb begin
      accept   = (state_q == S_IDLE) & start_E & ~Flush_E & ~reset;
      is_mul   = ~funct3_E[2];
      signed_a = (funct3_E == 3'b001) | (funct3_E == 3'b010) |
                 (funct3_E == 3'b100) | (funct3_E == 3'b110);
      signed_b = (funct3_E == 3'b001) | (funct3_E == 3'b100) | (funct3_E == 3'b110);
      sign_a   = signed_a & SrcA_E[XLEN-1];
      sign_b   = signed_b & SrcB_E[XLEN-1];
      mag_a    = sign_a ? -SrcA_E : SrcA_E;
      mag_b    = sign_b ? -SrcB_E : SrcB_E;
      div_zero = funct3_E[2] & (SrcB_E == '0);
      div_ovf  = funct3_E[2] & ~funct3_E[0] & (SrcA_E == INT_MIN) & (SrcB_E == '1);
      fast     = div_zero | div_ovf;
      if (div_zero) begin
         fast_res = funct3_E[1] ? SrcA_E : '1;
      end else begin
         fast_res = funct3_E[1] ? '0 : SrcA_E;
      end
   end

   logic [XLEN:0]     mul_sum, div_hi, div_diff;
   logic              div_ge;
   logic [AW-1:0]     mul_next, div_shift, div_next;
   logic [2*XLEN-1:0] prod_s;
   logic [XLEN-1:0]   quo_s, rem_s, adj_res;

   // Multiply: {hi+carry, multiplier} shifts right; divide: {remainder, quotient} shifts left.
   always_comb begin
      mul_sum   = acc_q[AW-1:XLEN] + (acc_q[0] ? {1'b0, opb_q} : '0);
      mul_next  = {1'b0, mul_sum, acc_q[XLEN-1:1]};
      div_shift = {acc_q[AW-2:0], 1'b0};
      div_hi    = div_shift[AW-1:XLEN];
      div_ge    = div_hi >= {1'b0, opb_q};
      div_diff  = div_hi - {1'b0, opb_q};
      div_next  = div_ge ? {div_diff, div_shift[XLEN-1:1], 1'b1} : div_shift;
      prod_s    = neg_q ? -acc_q[2*XLEN-1:0] : acc_q[2*XLEN-1:0];
      quo_s     = neg_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
      rem_s     = neg_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
      case (op_q)
         3'b000:                 adj_res = prod_s[XLEN-1:0];
         3'b001, 3'b010, 3'b011: adj_res = prod_s[2*XLEN-1:XLEN];
         3'b100, 3'b101:         adj_res = quo_s;
         default:                adj_res = rem_s;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (accept) state_d = fast ? S_DONE : S_CALC;
         S_CALC:  if (cnt_q == '0) state_d = S_ADJ;
         S_ADJ:   state_d = S_DONE;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      if (Flush_E) begin
         state_d = S_IDLE;
      end
   end

   always_comb begin
      busy      = (state_q != S_IDLE);
      done      = (state_q == S_DONE);
      stall_req = accept | (state_q == S_CALC) | (state_q == S_ADJ);
      result_M  = result_q;
      rd_M      = rd_q;
   end

   always_comb begin
      cnt_d    = cnt_q;
      op_d     = op_q;
      rd_lat_d = rd_lat_q;
      neg_d    = neg_q;
      acc_d    = acc_q;
      opb_d    = opb_q;
      result_d = result_q;
      rd_d     = rd_q;
      case (state_q)
         S_IDLE: begin
            if (accept) begin
               op_d     = funct3_E;
               rd_lat_d = rd_E;
               neg_d    = (funct3_E[2] & funct3_E[1]) ? sign_a : (sign_a ^ sign_b);
               acc_d    = {{(XLEN+1){1'b0}}, (is_mul ? mag_b : mag_a)};
               opb_d    = is_mul ? mag_a : mag_b;
               cnt_d    = CNT_INIT;
               if (fast) begin
                  result_d = fast_res;
                  rd_d     = rd_E;
               end
            end
         end
         S_CALC: begin
            acc_d = op_q[2] ? div_next : mul_next;
            if (cnt_q != '0) begin
               cnt_d = cnt_q - CNTW'(1);
            end
         end
         S_ADJ: begin
            if (!Flush_E) begin
               result_d = adj_res;
               rd_d     = rd_lat_q;
            end
         end
         default: begin
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q    <= '0;
         op_q     <= '0;
         rd_lat_q <= '0;
         neg_q    <= 1'b0;
         acc_q    <= '0;
         opb_q    <= '0;
         result_q <= '0;
         rd_q     <= '0;
      end else begin
         cnt_q    <= cnt_d;
         op_q     <= op_d;
         rd_lat_q <= rd_lat_d;
         neg_q    <= neg_d;
         acc_q    <= acc_d;
         opb_q    <= opb_d;
         result_q <= result_d;
         rd_q     <= rd_d;
      end
   end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - randomized and directed bench for muldiv_unit against an arithmetic model
module tb_muldiv_unit;
   localparam int XLEN = 32;

   logic        clk = 1'b0;
   logic        reset, start_E, Flush_E;
   logic [2:0]  funct3_E;
   logic [31:0] SrcA_E, SrcB_E;
   logic [4:0]  rd_E;
   logic        busy, done, stall_req;
   logic [31:0] result_M;
   logic [4:0]  rd_M;

   logic        start64, flush64;
   logic [2:0]  f64;
   logic [63:0] a64, b64;
   logic [4:0]  rdi64;
   logic        busy64, done64, stall64;
   logic [63:0] res64;
   logic [4:0]  rdm64;

   always #5 clk = ~clk;

   muldiv_unit #(.XLEN(32)) dut (
      .clk(clk), .reset(reset), .start_E(start_E), .funct3_E(funct3_E),
      .SrcA_E(SrcA_E), .SrcB_E(SrcB_E), .rd_E(rd_E), .Flush_E(Flush_E),
      .busy(busy), .done(done), .result_M(result_M), .rd_M(rd_M), .stall_req(stall_req)
   );

   muldiv_unit #(.XLEN(64)) dut64 (
      .clk(clk), .reset(reset), .start_E(start64), .funct3_E(f64),
      .SrcA_E(a64), .SrcB_E(b64), .rd_E(rdi64), .Flush_E(flush64),
      .busy(busy64), .done(done64), .result_M(res64), .rd_M(rdm64), .stall_req(stall64)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: actual %0h required %0h", nm, act, req);
      end
   endtask

   // Reference result from plain wide signed/unsigned arithmetic.
   function automatic logic [63:0] ref_op(input int w, input logic [2:0] f,
                                          input logic [63:0] a, input logic [63:0] b);
      logic signed [129:0] sa, sb, ua, ub, r;
      logic [63:0] mask;
      mask = (w == 32) ? 64'h0000_0000_FFFF_FFFF : 64'hFFFF_FFFF_FFFF_FFFF;
      if (w == 32) begin
         sa = $signed({{98{a[31]}}, a[31:0]});
         sb = $signed({{98{b[31]}}, b[31:0]});
         ua = {98'd0, a[31:0]};
         ub = {98'd0, b[31:0]};
      end else begin
         sa = $signed({{66{a[63]}}, a});
         sb = $signed({{66{b[63]}}, b});
         ua = {66'd0, a};
         ub = {66'd0, b};
      end
      case (f)
         3'd0: r = sa * sb;
         3'd1: r = (sa * sb) >>> w;
         3'd2: r = (sa * ub) >>> w;
         3'd3: r = (ua * ub) >>> w;
         3'd4: if ((b & mask) == 0) r = -1; else r = sa / sb;
         3'd5: if ((b & mask) == 0) r = -1; else r = ua / ub;
         3'd6: if ((b & mask) == 0) r = sa; else r = sa % sb;
         default: if ((b & mask) == 0) r = ua; else r = ua % ub;
      endcase
      return r[63:0] & mask;
   endfunction

   function automatic bit is_fast(input int w, input logic [2:0] f,
                                  input logic [63:0] a, input logic [63:0] b);
      logic [63:0] mn, ones;
      mn   = (w == 32) ? 64'h0000_0000_8000_0000 : 64'h8000_0000_0000_0000;
      ones = (w == 32) ? 64'h0000_0000_FFFF_FFFF : 64'hFFFF_FFFF_FFFF_FFFF;
      return (f[2] && b == 0) || ((f == 3'd4 || f == 3'd6) && a == mn && b == ones);
   endfunction

   // Transaction-level model of the 32-bit unit: one op in flight, completion edge, held result.
   int          cyc = 0;
   bit          pend = 0;
   int          due = 0;
   logic [63:0] exp_res = 0, last_res = 0;
   logic [4:0]  exp_rd = 0, last_rd = 0;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (reset) begin
         pend     <= 0;
         last_res <= 0;
         last_rd  <= 0;
      end else if (Flush_E) begin
         pend <= 0;
      end else if (pend) begin
         if (cyc + 1 == due) begin
            last_res <= exp_res;
            last_rd  <= exp_rd;
         end
         if (cyc == due) pend <= 0;
      end else if (start_E) begin
         pend    <= 1;
         exp_res <= ref_op(32, funct3_E, {32'd0, SrcA_E}, {32'd0, SrcB_E});
         exp_rd  <= rd_E;
         due     <= cyc + 1 + (is_fast(32, funct3_E, {32'd0, SrcA_E}, {32'd0, SrcB_E}) ? 0 : XLEN + 1);
         if (is_fast(32, funct3_E, {32'd0, SrcA_E}, {32'd0, SrcB_E})) begin
            last_res <= ref_op(32, funct3_E, {32'd0, SrcA_E}, {32'd0, SrcB_E});
            last_rd  <= rd_E;
         end
      end
   end

   always @(negedge clk) begin
      if (cyc >= 3) begin
         chk("cyc busy", busy, pend);
         chk("cyc done", done, pend && cyc == due);
         chk("cyc stall", stall_req, (pend && cyc < due) || (!pend && start_E && !Flush_E && !reset));
         chk("cyc result_M", result_M, last_res[31:0]);
         chk("cyc rd_M", rd_M, last_rd);
      end
   end

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 5))
         0:       return 32'd0;
         1:       return 32'hFFFF_FFFF;
         2:       return 32'h8000_0000;
         3:       return 32'($urandom_range(0, 15));
         4:       return 32'(0 - $urandom_range(1, 15));
         default: return $urandom;
      endcase
   endfunction

   task automatic run_op(input string nm, input logic [2:0] f, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] rd, input logic [31:0] req,
                         input int lat, input int noise_at);
      int n;
      n = -1;
      @(posedge clk); #1;
      start_E = 1; funct3_E = f; SrcA_E = a; SrcB_E = b; rd_E = rd;
      @(posedge clk); #1;
      start_E = 0;
      for (int k = 0; k < 200; k++) begin
         @(negedge clk);
         if (done) begin
            n = k;
            break;
         end
         @(posedge clk); #1;
         if (k == noise_at) begin
            start_E = 1; funct3_E = 3'd0; SrcA_E = $urandom; SrcB_E = $urandom; rd_E = 5'd31;
         end else begin
            start_E = 0;
         end
      end
      start_E = 0;
      chk({nm, " latency"}, 64'(n), 64'(lat));
      chk({nm, " result"}, result_M, req);
      chk({nm, " rd"}, rd_M, rd);
      chk({nm, " stall in done"}, stall_req, 0);
   endtask

   task automatic run64(input string nm, input logic [2:0] f, input logic [63:0] a,
                        input logic [63:0] b, input logic [4:0] rd, input logic [63:0] req,
                        input int lat);
      int n;
      n = -1;
      @(posedge clk); #1;
      start64 = 1; f64 = f; a64 = a; b64 = b; rdi64 = rd;
      @(posedge clk); #1;
      start64 = 0;
      for (int k = 0; k < 200; k++) begin
         @(negedge clk);
         if (done64) begin
            n = k;
            break;
         end
         @(posedge clk);
      end
      chk({nm, " latency"}, 64'(n), 64'(lat));
      chk({nm, " result"}, res64, req);
      chk({nm, " rd"}, rdm64, rd);
   endtask

   initial begin
      bit seen;
      int flush_at;
      logic [2:0]  rf;
      logic [63:0] ra, rb;
      reset = 1; start_E = 0; Flush_E = 0; funct3_E = 0; SrcA_E = 0; SrcB_E = 0; rd_E = 0;
      start64 = 0; flush64 = 0; f64 = 0; a64 = 0; b64 = 0; rdi64 = 0;
      repeat (3) @(posedge clk);
      #1 reset = 0;
      @(negedge clk);
      chk("reset busy", busy, 0);
      chk("reset done", done, 0);
      chk("reset stall", stall_req, 0);
      chk("reset result_M", result_M, 0);
      chk("reset rd_M", rd_M, 0);
      chk("reset result_M 64", res64, 0);

      chk("model MULH", ref_op(32, 3'd1, 64'h8000_0000, 64'h8000_0000), 64'h4000_0000);
      chk("model MULHSU", ref_op(32, 3'd2, 64'hFFFF_FFFF, 64'hFFFF_FFFF), 64'hFFFF_FFFF);
      chk("model DIV ovf", ref_op(32, 3'd4, 64'h8000_0000, 64'hFFFF_FFFF), 64'h8000_0000);
      chk("model REM neg", ref_op(32, 3'd6, 64'hFFFF_FFF9, 64'd2), 64'hFFFF_FFFF);

      run_op("MUL 7*-3", 3'd0, 32'd7, 32'hFFFF_FFFD, 5'd1, 32'hFFFF_FFEB, 33, -1);
      run_op("MULH", 3'd1, 32'h8000_0000, 32'h8000_0000, 5'd2, 32'h4000_0000, 33, -1);
      run_op("MULHSU", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 32'hFFFF_FFFF, 33, -1);
      run_op("MULHU", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4, 32'hFFFF_FFFE, 33, -1);
      run_op("DIV -7/2", 3'd4, 32'hFFFF_FFF9, 32'd2, 5'd5, 32'hFFFF_FFFD, 33, -1);
      run_op("REM -7/2", 3'd6, 32'hFFFF_FFF9, 32'd2, 5'd6, 32'hFFFF_FFFF, 33, -1);
      run_op("DIVU 100/7", 3'd5, 32'd100, 32'd7, 5'd8, 32'd14, 33, -1);
      run_op("REMU 100/7", 3'd7, 32'd100, 32'd7, 5'd7, 32'd2, 33, -1);

      // Flush mid-divide: no done, previous result held.
      @(posedge clk); #1;
      start_E = 1; funct3_E = 3'd4; SrcA_E = 32'd1000; SrcB_E = 32'd3; rd_E = 5'd12;
      @(posedge clk); #1;
      start_E = 0;
      repeat (9) @(posedge clk);
      #1 Flush_E = 1;
      @(posedge clk); #1;
      Flush_E = 0;
      @(negedge clk);
      chk("flush busy", busy, 0);
      seen = 0;
      repeat (40) begin
         @(negedge clk);
         if (done) seen = 1;
      end
      chk("flush no done", seen, 0);
      chk("flush result held", result_M, 32'd2);
      chk("flush rd held", rd_M, 5'd7);

      @(posedge clk); #1;
      start_E = 1; Flush_E = 1; funct3_E = 3'd4; SrcA_E = 32'd50; SrcB_E = 32'd5; rd_E = 5'd13;
      @(posedge clk); #1;
      start_E = 0; Flush_E = 0;
      @(negedge clk);
      chk("flush+start busy", busy, 0);
      chk("flush+start result", result_M, 32'd2);

      run_op("DIVU 5/0", 3'd5, 32'd5, 32'd0, 5'd9, 32'hFFFF_FFFF, 0, -1);
      run_op("REMU 5/0", 3'd7, 32'd5, 32'd0, 5'd10, 32'd5, 0, -1);
      run_op("DIV ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 32'h8000_0000, 0, -1);
      run_op("REM ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd14, 32'd0, 0, -1);
      run_op("REM -5/0", 3'd6, 32'hFFFF_FFFB, 32'd0, 5'd15, 32'hFFFF_FFFB, 0, -1);

      // Reset in the middle of CALC.
      @(posedge clk); #1;
      start_E = 1; funct3_E = 3'd0; SrcA_E = 32'd9; SrcB_E = 32'd9; rd_E = 5'd3;
      @(posedge clk); #1;
      start_E = 0;
      repeat (5) @(posedge clk);
      #1 reset = 1;
      @(posedge clk); #1;
      reset = 0;
      @(negedge clk);
      chk("rst busy", busy, 0);
      chk("rst done", done, 0);
      chk("rst stall", stall_req, 0);
      chk("rst result_M", result_M, 0);
      chk("rst rd_M", rd_M, 0);

      run_op("DIVU start ignored", 3'd5, 32'd100, 32'd7, 5'd4, 32'd14, 33, 5);

      for (int i = 0; i < 200; i++) begin
         @(posedge clk); #1;
         Flush_E = 0;
         start_E = 1; funct3_E = 3'($urandom_range(0, 7)); SrcA_E = pick(); SrcB_E = pick();
         rd_E = 5'($urandom_range(0, 31));
         flush_at = ($urandom_range(0, 5) == 0) ? $urandom_range(0, 40) : -1;
         @(posedge clk); #1;
         start_E = 0;
         seen = 0;
         for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (!busy) begin
               seen = 1;
               break;
            end
            @(posedge clk); #1;
            Flush_E = (k == flush_at);
            start_E = ($urandom_range(0, 7) == 0);
            if (start_E) begin
               funct3_E = 3'($urandom_range(0, 7)); SrcA_E = pick(); SrcB_E = pick();
            end
         end
         chk("random returns idle", seen, 1);
      end
      @(posedge clk); #1;
      start_E = 0; Flush_E = 0;
      repeat (40) @(posedge clk);

      run64("MUL64 3*5", 3'd0, 64'd3, 64'd5, 5'd17, 64'd15, 65);
      run64("MULHU64", 3'd3, '1, '1, 5'd18, 64'hFFFF_FFFF_FFFF_FFFE, 65);
      run64("DIV64 ovf", 3'd4, 64'h8000_0000_0000_0000, '1, 5'd19, 64'h8000_0000_0000_0000, 0);
      for (int i = 0; i < 6; i++) begin
         rf = 3'($urandom_range(0, 7));
         ra = {$urandom, $urandom};
         rb = (i == 5) ? 64'd0 : {$urandom, $urandom} >> $urandom_range(0, 40);
         run64("rand64", rf, ra, rb, 5'(i + 20), ref_op(64, rf, ra, rb),
               is_fast(64, rf, ra, rb) ? 0 : 65);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global timeout: actual running required finished");
      $fatal(1, "timeout");
   end
endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative RV32M/RV64M multiply/divide unit that sits beside the ALU in the Execute stage of the pipelined datapath. It is parametrised in operand width. It accepts one M-extension operation from the ID/EX register and asserts a stall request to the hazard unit while the operation is in flight. It returns the result and destination register, which are then written into the EX/MEM register. Division by zero and signed overflow take a one-cycle fast path.

## Interface
- XLEN, 32, operand/result width; legal values are 32 and 64.
- CNTW, $clog2(XLEN), width of the iteration counter.

- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high.
- start_E  input  1  operation request; high for the whole cycle with valid operands.
- funct3_E  input  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- SrcA_E  input  XLEN  rs1 operand, already forwarded.
- SrcB_E  input  XLEN  rs2 operand, already forwarded.
- rd_E  input  5  destination register.
- Flush_E  input  1  aborts the in-flight operation.
- busy  output  1  state != IDLE.
- done  output  1  one-cycle pulse; result_M and rd_M are valid in that cycle.
- result_M  output  XLEN  result register.
- rd_M  output  5  captured destination register.
- stall_req  output  1  request to hold F/D/E; defined below.

## Operation
- States: IDLE, CALC, ADJ, DONE.
- IDLE, start_E=1, Flush_E=0:
  - Latch funct3, rd and operand magnitudes.
  - Record the result sign:
    - product sign = signA^signB;
    - quotient sign = signA^signB;
    - remainder sign = signA.
  - Signedness per op:
    - MULH, DIV, REM: both operands signed.
    - MULHSU: A signed, B unsigned.
    - All others: both operands unsigned.
  - Special case, go directly to DONE and write result_M:
    - divisor==0: DIV/DIVU → all ones; REM/REMU → SrcA_E.
    - Signed overflow, DIV/REM with A=1<<(XLEN-1) and B=all ones: DIV → A; REM → 0.
  - Otherwise: go to CALC, counter=XLEN-1.
- CALC: one step per cycle; when counter==0, go to ADJ.
  - Multiply: radix-2 shift-add into a 2*XLEN accumulator.
  - Divide: restoring, one quotient bit per cycle.
- ADJ:
  - Negate the magnitude result (two's complement, 2*XLEN wide for multiplies) if its recorded sign is 1.
  - Select the result: MUL → low XLEN bits; MULH* → high XLEN bits; DIV* → quotient; REM* → remainder.
  - Write result_M and rd_M; go to DONE.
- DONE: done=1; unconditionally go to IDLE. start_E is ignored in DONE.
- start_E while busy: ignored; the operands are not re-latched.
- stall_req = (state==IDLE & start_E & ~Flush_E) | state==CALC | state==ADJ. It is low in DONE, so the pipeline advances in the cycle done is high.
- Flush_E, any state: next state IDLE; done is not asserted; result_M and rd_M keep their previous values. Flush_E has priority over start_E.
- reset: state IDLE, counter 0, result_M 0, rd_M 0, done 0, busy 0, stall_req 0. reset has priority over Flush_E and start_E.
- All arithmetic is internal; the accumulators are 2*XLEN+1 bits wide. No overflow is visible except the defined RISC-V cases.

## Timing
- Edge 0 is the edge that samples start_E=1.
- Normal op:
  - CALC occupies edges 1..XLEN.
  - ADJ→DONE occurs at edge XLEN+1.
  - done is high between edges XLEN+1 and XLEN+2, i.e. XLEN+2 cycles of latency (34 for XLEN=32).
- Fast path: done is high in the cycle after edge 0 (1-cycle latency); stall_req is high only in the request cycle.
- busy is high from edge 0 through the DONE cycle.
- result_M and rd_M are registered and change only on ADJ→DONE or on a fast-path entry.
- Back-to-back: the earliest next start_E is sampled on the edge leaving DONE. No start_E is accepted in DONE.

## Test plan
- MUL 7 × 0xFFFFFFFD → result_M 0xFFFFFFEB, done exactly 34 cycles after the start edge, stall_req low in the done cycle.
- MULH 0x80000000 × 0x80000000 → 0x40000000; MULHSU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFF; MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE.
- DIV −7/2 → 0xFFFFFFFD; REM −7/2 → 0xFFFFFFFF; DIVU 100/7 → 14; REMU 100/7 → 2. Each has rd_M equal to the latched rd_E.
- DIVU 5/0 → 0xFFFFFFFF and REMU 5/0 → 5, done 1 cycle after start. DIV 0x80000000/0xFFFFFFFF → 0x80000000 and REM → 0, also with 1-cycle latency.
- Flush_E at cycle 10 of a DIV → IDLE next cycle, no done pulse, result_M unchanged. Flush_E together with start_E in IDLE → not accepted.
- reset mid-CALC → all outputs 0 next cycle. start_E pulsed mid-CALC with new operands → ignored; the original result is returned at cycle 34. XLEN=64 MUL 3×5 → 15 at cycle 66.
